ebp_frame_reader: RTL and testbench

//  Reads a 32-bit stack-frame operand at [ebp + disp8] over the byte-wide data-memory read port.

---
 rtl/ebp_frame_reader_if.sv | 30 +++
 rtl/ebp_frame_reader.sv | 93 +++++++++
 tb/tb_ebp_frame_reader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ebp_frame_reader_if.sv
// Bundles the frame reader's request, byte-wide memory and response signals.
// slave: the frame reader itself. master: the decode/memory/consumer environment.
interface ebp_frame_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DISP_W = 8,
  parameter int NBYTES = 4
);
  logic [ADDR_W-1:0]   ebp;
  logic                req_valid;
  logic [DISP_W-1:0]   req_disp;
  logic                req_ready;
  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [7:0]          mem_rdata;
  logic                rsp_valid;
  logic [8*NBYTES-1:0] rsp_data;
  logic [ADDR_W-1:0]   rsp_addr;
  logic                rsp_ready;

  modport slave (
    input  ebp, req_valid, req_disp, mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_addr
  );

  modport master (
    output ebp, req_valid, req_disp, mem_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/ebp_frame_reader.sv
// Reads a little-endian word at [ebp + disp] one byte at a time; 4*(1+waits)+1 cycles accept-to-rsp_valid.
// One request in flight; req_ready only in IDLE, response held in DONE until rsp_ready.
module ebp_frame_reader #(
  parameter int ADDR_W = 32,
  parameter int DISP_W = 8,
  parameter int NBYTES = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  ebp_frame_reader_if.slave  bus
);
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [KW-1:0]       k_q;
  logic [8*NBYTES-1:0] data_q;
  logic                mem_rd_q;
  logic                rsp_valid_q;
  logic                req_ready_q;
  logic [ADDR_W-1:0]   base_d;
  logic                last_byte;

  // Displacement is two's complement; the sum wraps modulo 2^ADDR_W.
  always_comb begin
    base_d    = bus.ebp + {{(ADDR_W-DISP_W){bus.req_disp[DISP_W-1]}}, bus.req_disp};
    last_byte = (k_q == KW'(NBYTES-1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      mem_addr_q  <= '0;
      k_q         <= '0;
      data_q      <= '0;
      mem_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            base_q      <= base_d;
            mem_addr_q  <= base_d;
            k_q         <= '0;
            mem_rd_q    <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= READ;
          end
        end
        READ: begin
          if (bus.mem_ack) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (k_q == KW'(i)) data_q[8*i +: 8] <= bus.mem_rdata;
            end
            if (last_byte) begin
              mem_rd_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              k_q        <= k_q + KW'(1);
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_rd_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_addr  = base_q;
endmodule

// File: tb/tb_ebp_frame_reader.sv
// Directed bench for ebp_frame_reader with a byte memory model that inserts a fixed number of wait states.
module tb_ebp_frame_reader;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ebp_frame_reader_if #(.ADDR_W(32), .DISP_W(8), .NBYTES(4)) bus ();

  ebp_frame_reader #(.ADDR_W(32), .DISP_W(8), .NBYTES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: acks after wait_cycles idle cycles per byte, logs each acked address.
  logic        model_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [7:0]  model_rdata = 8'h00;
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          nack = 0;
  logic [7:0]  rbytes [4];
  logic [31:0] addr_log [4];
  logic [31:0] held_addr = 32'h0;

  assign bus.mem_ack   = model_ack | stray_ack;
  assign bus.mem_rdata = model_rdata;

  always @(negedge clock) begin
    if (!bus.mem_rd) begin
      model_ack = 1'b0;
      wcnt = 0;
      nack = 0;
    end else begin
      if (wcnt == 0) held_addr = bus.mem_addr;
      else check("addr_hold", bus.mem_addr, held_addr);
      if (wcnt == wait_cycles) begin
        model_ack   = 1'b1;
        model_rdata = rbytes[nack % 4];
        if (nack < 4) addr_log[nack] = bus.mem_addr;
        nack++;
        wcnt = 0;
      end else begin
        model_ack = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic run_req(input string tag, input logic [31:0] e, input logic [7:0] d, input int waits,
                         input logic [31:0] word, input int hold, input bit chg_ebp, input bit stray_req);
    logic [31:0] exp_base;
    int lat;
    exp_base = e + {{24{d[7]}}, d};
    wait_cycles = waits;
    for (int i = 0; i < 4; i++) begin
      rbytes[i]   = word[8*i +: 8];
      addr_log[i] = 32'hDEAD_BEEF;
    end
    @(negedge clock);
    check({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.ebp = e;
    bus.req_disp = d;
    bus.req_valid = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (chg_ebp && lat == 2) bus.ebp = 32'h5555_0000;
      if (stray_req && lat == 3) begin
        bus.req_disp = 8'h40;
        bus.req_valid = 1'b1;
      end
      if (stray_req && lat == 4) bus.req_valid = 1'b0;
    end while (!bus.rsp_valid && lat < 100);
    check({tag, "_latency"}, lat, 4 * (waits + 1) + 1);
    check({tag, "_rsp_data"}, bus.rsp_data, word);
    check({tag, "_rsp_addr"}, bus.rsp_addr, exp_base);
    for (int i = 0; i < 4; i++) check({tag, "_addr_seq"}, addr_log[i], exp_base + i);
    check({tag, "_busy"}, {31'b0, bus.req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "_hold_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      check({tag, "_hold_data"}, bus.rsp_data, word);
      check({tag, "_hold_addr"}, bus.rsp_addr, exp_base);
      check({tag, "_hold_busy"}, {31'b0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clock);
    check({tag, "_rsp_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, "_idle_rd"}, {31'b0, bus.mem_rd}, 32'd0);
  endtask

  initial begin
    int n;
    bus.ebp = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_disp = 8'h00;
    bus.rsp_ready = 1'b0;
    #12;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_rsp_addr", bus.rsp_addr, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    run_req("basic", 32'h0000_0999, 8'hFC, 0, 32'h4433_2211, 0, 1'b0, 1'b0);
    run_req("waits", 32'h0000_1000, 8'h08, 2, 32'hA1B2_C3D4, 0, 1'b0, 1'b0);
    run_req("wrap", 32'hFFFF_FFFE, 8'h00, 0, 32'h0102_0304, 0, 1'b0, 1'b0);
    run_req("bp_snap", 32'h0000_2000, 8'h80, 1, 32'hCAFE_F00D, 3, 1'b1, 1'b0);

    // Abort after the second byte has been taken.
    wait_cycles = 0;
    @(negedge clock);
    bus.ebp = 32'h0000_3000;
    bus.req_disp = 8'h10;
    bus.req_valid = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.mem_addr != 32'h0000_3012 && n < 50);
    check("rst_mid_reach", bus.mem_addr, 32'h0000_3012);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("rst_mid_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    run_req("after_rst", 32'h0000_3000, 8'h10, 0, 32'h89AB_CDEF, 0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      stray_ack = 1'b1;
      @(negedge clock);
      stray_ack = 1'b0;
      check("stray_ack_ready", {31'b0, bus.req_ready}, 32'd1);
      check("stray_ack_rd", {31'b0, bus.mem_rd}, 32'd0);
      check("stray_ack_valid", {31'b0, bus.rsp_valid}, 32'd0);
    end
    run_req("stray_req", 32'h0000_4000, 8'h04, 0, 32'h5A6B_7C8D, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stray_post_rd", {31'b0, bus.mem_rd}, 32'd0);
      check("stray_post_valid", {31'b0, bus.rsp_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
